// File: rtl/cpu_pkg.sv
// Shared opcode constants, writeback FSM encoding and opcode classifier.
package cpu_pkg;

  localparam logic [1:0] OP_ALU_HI = 2'b00;
  localparam logic [5:0] OP_LW     = 6'b010000;
  localparam logic [5:0] OP_SW     = 6'b010001;
  localparam logic [5:0] OP_BEQ    = 6'b100000;
  localparam logic [5:0] OP_JMP    = 6'b100001;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MEM  = 3'd1,
    S_WB   = 3'd2,
    S_BR   = 3'd3,
    S_NOP  = 3'd4
  } wb_state_t;

  typedef enum logic [2:0] {
    K_ALU = 3'd0,
    K_LW  = 3'd1,
    K_SW  = 3'd2,
    K_BEQ = 3'd3,
    K_JMP = 3'd4,
    K_NOP = 3'd5
  } op_kind_t;

  function automatic op_kind_t op_kind(input logic [5:0] op);
    op_kind_t k;
    if (op[5:4] == OP_ALU_HI) begin
      k = K_ALU;
    end else begin
      case (op)
        OP_LW:   k = K_LW;
        OP_SW:   k = K_SW;
        OP_BEQ:  k = K_BEQ;
        OP_JMP:  k = K_JMP;
        default: k = K_NOP;
      endcase
    end
    return k;
  endfunction

endpackage

// File: rtl/writeback_unit_if.sv
// Execute handshake, data-memory bus and register/PC update signals.
interface writeback_unit_if;
  logic        ex_valid;
  logic        ex_ready;
  logic [5:0]  ex_op;
  logic [4:0]  ex_rd;
  logic [31:0] ex_alu;
  logic [31:0] ex_store;
  logic        ex_zero;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        reg_update;
  logic [31:0] reg_i;
  logic [4:0]  reg_dst;
  logic        pc_load;
  logic [31:0] pc_target;
  logic        bus_err;

  modport slave (
    input  ex_valid, ex_op, ex_rd, ex_alu, ex_store, ex_zero, mem_rdata, mem_ack,
    output ex_ready, mem_req, mem_we, mem_addr, mem_wdata,
    output reg_update, reg_i, reg_dst, pc_load, pc_target, bus_err
  );

  modport master (
    output ex_valid, ex_op, ex_rd, ex_alu, ex_store, ex_zero, mem_rdata, mem_ack,
    input  ex_ready, mem_req, mem_we, mem_addr, mem_wdata,
    input  reg_update, reg_i, reg_dst, pc_load, pc_target, bus_err
  );
endinterface

// File: rtl/wb_mem_port.sv
// Data-memory request/ack handshake with an abort after MEM_TIMEOUT unacked cycles.
module wb_mem_port #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        done,
  output logic [31:0] rdata,
  output logic        timeout
);

  localparam int CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);

  logic [CW-1:0] cnt;

  // an ack in the final allowed cycle still completes the access
  assign done    = mem_req && mem_ack;
  assign timeout = mem_req && !mem_ack && (cnt == LAST);
  assign rdata   = mem_rdata;

  // request launch, hold until ack or expiry, count unacked cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cnt       <= '0;
    end else if (start) begin
      mem_req   <= 1'b1;
      mem_we    <= we;
      mem_addr  <= addr;
      mem_wdata <= wdata;
      cnt       <= '0;
    end else if (done || timeout) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      cnt       <= '0;
    end else if (mem_req) begin
      cnt       <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/writeback_unit.sv
// Write-back stage: memory access, register update strobe and PC load.
//
// state  | meaning
// IDLE   | ready for the next retired instruction
// MEM    | data-memory access in flight (LW/SW)
// WB     | register write strobe
// BR     | PC load strobe (taken BEQ or JMP)
// NOP    | unknown opcode consumed, no outputs
module writeback_unit #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  writeback_unit_if.slave wb
);
  import cpu_pkg::*;

  wb_state_t   state, state_nxt;
  op_kind_t    kind_in, kind_q;
  logic [4:0]  rd_q;
  logic        zero_q;
  logic [31:0] reg_i_q, pc_target_q;
  logic [4:0]  reg_dst_q;
  logic        bus_err_q;
  logic        accept, mem_start, mem_done, mem_timeout;
  logic        ex_ready_c, reg_update_c, pc_load_c;
  logic        mem_req_c, mem_we_c;
  logic [31:0] mem_addr_c, mem_wdata_c, mem_rdata_c;

  assign kind_in = op_kind(wb.ex_op);
  assign accept  = wb.ex_valid && (state == S_IDLE);

  wb_mem_port #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_mem (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (mem_start),
    .we        (kind_in == K_SW),
    .addr      (wb.ex_alu),
    .wdata     (wb.ex_store),
    .mem_ack   (wb.mem_ack),
    .mem_rdata (wb.mem_rdata),
    .mem_req   (mem_req_c),
    .mem_we    (mem_we_c),
    .mem_addr  (mem_addr_c),
    .mem_wdata (mem_wdata_c),
    .done      (mem_done),
    .rdata     (mem_rdata_c),
    .timeout   (mem_timeout)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // next-state decision
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          case (kind_in)
            K_ALU:       state_nxt = S_WB;
            K_LW, K_SW:  state_nxt = S_MEM;
            K_BEQ, K_JMP: state_nxt = S_BR;
            default:     state_nxt = S_NOP;
          endcase
        end
      end
      S_MEM: begin
        if (mem_done)         state_nxt = (kind_q == K_LW) ? S_WB : S_IDLE;
        else if (mem_timeout) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // strobes decoded from state
  always_comb begin
    ex_ready_c   = 1'b0;
    reg_update_c = 1'b0;
    pc_load_c    = 1'b0;
    mem_start    = 1'b0;
    case (state)
      S_IDLE: begin
        ex_ready_c = 1'b1;
        mem_start  = wb.ex_valid && ((kind_in == K_LW) || (kind_in == K_SW));
      end
      S_WB:    reg_update_c = 1'b1;
      S_BR:    pc_load_c    = (kind_q == K_JMP) || zero_q;
      default: ;
    endcase
  end

  // instruction latch and held data outputs; outputs only move when their strobe follows
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kind_q      <= K_ALU;
      rd_q        <= '0;
      zero_q      <= 1'b0;
      reg_i_q     <= '0;
      reg_dst_q   <= '0;
      pc_target_q <= '0;
      bus_err_q   <= 1'b0;
    end else begin
      bus_err_q <= mem_timeout;
      if (accept) begin
        kind_q <= kind_in;
        rd_q   <= wb.ex_rd;
        zero_q <= wb.ex_zero;
        if (kind_in == K_ALU) begin
          reg_i_q   <= wb.ex_alu;
          reg_dst_q <= wb.ex_rd;
        end
        if ((kind_in == K_JMP) || ((kind_in == K_BEQ) && wb.ex_zero)) begin
          pc_target_q <= wb.ex_alu;
        end
      end
      if ((state == S_MEM) && mem_done && (kind_q == K_LW)) begin
        reg_i_q   <= mem_rdata_c;
        reg_dst_q <= rd_q;
      end
    end
  end

  assign wb.ex_ready   = ex_ready_c;
  assign wb.mem_req    = mem_req_c;
  assign wb.mem_we     = mem_we_c;
  assign wb.mem_addr   = mem_addr_c;
  assign wb.mem_wdata  = mem_wdata_c;
  assign wb.reg_update = reg_update_c;
  assign wb.reg_i      = reg_i_q;
  assign wb.reg_dst    = reg_dst_q;
  assign wb.pc_load    = pc_load_c;
  assign wb.pc_target  = pc_target_q;
  assign wb.bus_err    = bus_err_q;

endmodule
